// File: rtl/data_repacker.sv
// -----------------------------------------------------------------------------
// data_repacker
//
// Packs a sparse element stream into dense output beats. Kept input elements
// (in_keep[i]=1) are compacted in order into an element buffer. Full output
// beats of NUM_OUT elements are emitted from it. On in_last the packet tail is
// flushed as a final beat with a contiguous keep and out_last=1. A packet with
// no kept tail still gets a keep=0 marker beat. The input and output widths
// are independent, so the block also converts widths.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/keep/last      input beat, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid/in_ready      input handshake (in_ready depends on state only)
//   out_data/keep/last     packed output beat, lowest element index first
//   out_valid/out_ready    output handshake (AXI-Stream hold rules)
//
// Optional feature (macro DATA_REPACKER_STATS_EN):
//   stat_in_elems   accepted kept elements
//   stat_out_beats  output handshakes
//   stat_packets    output handshakes with out_last
//   All three are 32-bit counters that wrap.
// -----------------------------------------------------------------------------
module data_repacker #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 8,
    parameter int NUM_OUT    = 8,
    parameter int CAP        = NUM_IN + NUM_OUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_IN-1:0]             in_keep,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]            out_keep,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef DATA_REPACKER_STATS_EN
    ,
    output logic [31:0]                   stat_in_elems,
    output logic [31:0]                   stat_out_beats,
    output logic [31:0]                   stat_packets
`endif
);

    localparam int CW = $clog2(CAP + 1);
    localparam logic [CW-1:0] NUM_OUT_C    = CW'(NUM_OUT);
    localparam logic [CW-1:0] FILL_LIMIT_C = CW'(CAP - NUM_IN);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // The buffer must hold a worst-case input beat on top of a full output beat.
    if (CAP < NUM_IN + NUM_OUT) begin : g_cap_check
        $error("data_repacker: CAP must be >= NUM_IN + NUM_OUT");
    end

    // Count of set bits in a keep vector, sized to the element counter.
    function automatic logic [CW-1:0] popcount(input logic [NUM_IN-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Element buffer, slot 0 in the low bits.
    logic [CAP*DATA_WIDTH-1:0]     buf_r;
    logic [CAP*DATA_WIDTH-1:0]     shifted_s;
    logic [CAP*DATA_WIDTH-1:0]     buf_next_s;
    logic [CW-1:0]                 cnt_r;
    logic [CW-1:0]                 cnt_next_s;
    logic [CW-1:0]                 pop_cnt_s;
    logic [CW-1:0]                 push_cnt_s;
    logic [CW-1:0]                 wr_pos_s;
    state_e                        state_r;
    state_e                        state_next_s;
    logic                          in_ready_r;
    logic [NUM_OUT*DATA_WIDTH-1:0] out_data_r;
    logic [NUM_OUT-1:0]            out_keep_r;
    logic                          out_last_r;
    logic                          out_valid_r;
    logic                          accept_s;
    logic                          load_en_s;
    logic                          tail_pending_s;
    logic                          pop_full_s;
    logic                          pop_tail_s;
    logic [NUM_OUT-1:0]            tail_keep_s;

    assign in_ready  = in_ready_r;
    assign out_data  = out_data_r;
    assign out_keep  = out_keep_r;
    assign out_last  = out_last_r;
    assign out_valid = out_valid_r;

    // Handshake decode and choice of what (if anything) the output register pops.
    always_comb begin
        accept_s       = in_valid && in_ready_r;
        load_en_s      = !out_valid_r || out_ready;
        // A tail beat already sitting in the output register must not be
        // regenerated in the cycle it handshakes (cnt is 0 then, still DRAIN).
        tail_pending_s = out_valid_r && out_last_r;
        pop_full_s     = 1'b0;
        pop_tail_s     = 1'b0;
        if (load_en_s) begin
            if ((cnt_r >= NUM_OUT_C) &&
                ((state_r == ST_FILL) || (cnt_r > NUM_OUT_C))) begin
                pop_full_s = 1'b1;
            end else if ((state_r == ST_DRAIN) && !tail_pending_s) begin
                pop_tail_s = 1'b1;
            end else begin
                pop_full_s = 1'b0;
            end
        end else begin
            pop_full_s = 1'b0;
        end
        if (pop_full_s) begin
            pop_cnt_s = NUM_OUT_C;
        end else if (pop_tail_s) begin
            pop_cnt_s = cnt_r;
        end else begin
            pop_cnt_s = {CW{1'b0}};
        end
        for (int e = 0; e < NUM_OUT; e++) begin
            tail_keep_s[e] = (CW'(e) < cnt_r);
        end
    end

    // Next buffer contents: shift out popped elements, then append kept inputs.
    always_comb begin
        push_cnt_s = popcount(in_keep & {NUM_IN{accept_s}});
        shifted_s  = buf_r >> (32'(pop_cnt_s) * 32'(DATA_WIDTH));
        buf_next_s = shifted_s;
        wr_pos_s   = cnt_r - pop_cnt_s;
        for (int i = 0; i < NUM_IN; i++) begin
            if (accept_s && in_keep[i]) begin
                buf_next_s[32'(wr_pos_s)*32'(DATA_WIDTH) +: DATA_WIDTH] =
                    in_data[i*DATA_WIDTH +: DATA_WIDTH];
                wr_pos_s = wr_pos_s + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                wr_pos_s = wr_pos_s;
            end
        end
        cnt_next_s = cnt_r - pop_cnt_s + push_cnt_s;
    end

    // Packet state: FILL accepts input, DRAIN flushes the tail until it handshakes.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (accept_s && in_last) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (out_valid_r && out_ready && out_last_r) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_FILL;
        endcase
    end

    // State, occupancy, buffer and registered in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FILL;
            cnt_r      <= {CW{1'b0}};
            buf_r      <= {(CAP*DATA_WIDTH){1'b0}};
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            buf_r      <= buf_next_s;
            in_ready_r <= (state_next_s == ST_FILL) && (cnt_next_s <= FILL_LIMIT_C);
        end
    end

    // Output beat register; only reloads when empty or being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_keep_r  <= {NUM_OUT{1'b0}};
            out_data_r  <= {(NUM_OUT*DATA_WIDTH){1'b0}};
        end else if (load_en_s) begin
            if (pop_full_s) begin
                out_valid_r <= 1'b1;
                out_last_r  <= 1'b0;
                out_keep_r  <= {NUM_OUT{1'b1}};
                out_data_r  <= buf_r[NUM_OUT*DATA_WIDTH-1:0];
            end else if (pop_tail_s) begin
                out_valid_r <= 1'b1;
                out_last_r  <= 1'b1;
                out_keep_r  <= tail_keep_s;
                out_data_r  <= buf_r[NUM_OUT*DATA_WIDTH-1:0];
            end else begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
                out_keep_r  <= {NUM_OUT{1'b0}};
            end
        end
    end

`ifdef DATA_REPACKER_STATS_EN
    logic [31:0] stat_in_elems_r;
    logic [31:0] stat_out_beats_r;
    logic [31:0] stat_packets_r;

    assign stat_in_elems  = stat_in_elems_r;
    assign stat_out_beats = stat_out_beats_r;
    assign stat_packets   = stat_packets_r;

    // Free-running traffic counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_in_elems_r  <= 32'd0;
            stat_out_beats_r <= 32'd0;
            stat_packets_r   <= 32'd0;
        end else begin
            stat_in_elems_r <= stat_in_elems_r + 32'(push_cnt_s);
            if (out_valid_r && out_ready) begin
                stat_out_beats_r <= stat_out_beats_r + 32'd1;
            end
            if (out_valid_r && out_ready && out_last_r) begin
                stat_packets_r <= stat_packets_r + 32'd1;
            end
        end
    end
`endif

endmodule
